// File: rtl/pc_gen.sv
// Fetch address generator: prioritised redirects (trap > branch > refill),
// sequential advance on handshake, redirect epoch and misaligned-target reporting.
module pc_gen #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STEP       = 4,
  parameter int unsigned ALIGN_BITS = 2,
  parameter int unsigned EPOCH_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    rst_addr,
  input  logic               trap_take,
  input  logic [XLEN-1:0]    trap_addr,
  input  logic               branch_take,
  input  logic [XLEN-1:0]    branch_addr,
  input  logic               refill_take,
  input  logic [XLEN-1:0]    refill_addr,
  input  logic               halt,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [XLEN-1:0]    addr,
  output logic [EPOCH_W-1:0] epoch,
  output logic               misalign_err,
  output logic [XLEN-1:0]    err_addr
);

  localparam logic [XLEN-1:0] AlignMask = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  logic               run_q;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    err_addr_q, err_addr_d;

  logic               redirect;
  logic               misaligned;
  logic               advance;
  logic [XLEN-1:0]    target;

  assign fetch_valid  = run_q & ~halt;
  assign addr         = addr_q;
  assign epoch        = epoch_q;
  assign misalign_err = err_q;
  assign err_addr     = err_addr_q;

  always_comb begin
    redirect   = trap_take | branch_take | refill_take;
    // Only the winning target matters; losing requests never reach the checker.
    if (trap_take) begin
      target = trap_addr;
    end else if (branch_take) begin
      target = branch_addr;
    end else begin
      target = refill_addr;
    end
    misaligned = redirect && ((target & AlignMask) != '0);
    advance    = fetch_valid & fetch_ready;

    addr_d     = addr_q;
    epoch_d    = epoch_q;
    err_d      = misaligned;
    err_addr_d = err_addr_q;

    if (redirect) begin
      addr_d  = target & ~AlignMask;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (advance) begin
      addr_d = addr_q + XLEN'(STEP);
    end

    if (misaligned) begin
      err_addr_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= 1'b0;
      addr_q     <= rst_addr & ~AlignMask;
      epoch_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      run_q      <= 1'b1;
      addr_q     <= addr_d;
      epoch_q    <= epoch_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen: each row is driven before a rising edge and the
// expected post-edge outputs are compared 1 ns after that edge.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic [31:0] rst_addr;
  logic        trap_take, branch_take, refill_take;
  logic [31:0] trap_addr, branch_addr, refill_addr;
  logic        halt, fetch_ready;
  logic        fetch_valid;
  logic [31:0] addr;
  logic [2:0]  epoch;
  logic        misalign_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .XLEN(32),
    .STEP(4),
    .ALIGN_BITS(2),
    .EPOCH_W(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rst_addr    (rst_addr),
    .trap_take   (trap_take),
    .trap_addr   (trap_addr),
    .branch_take (branch_take),
    .branch_addr (branch_addr),
    .refill_take (refill_take),
    .refill_addr (refill_addr),
    .halt        (halt),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .addr        (addr),
    .epoch       (epoch),
    .misalign_err(misalign_err),
    .err_addr    (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [31:0] ra;
    logic        tt;
    logic [31:0] ta;
    logic        bt;
    logic [31:0] ba;
    logic        ft;
    logic [31:0] fa;
    logic        h;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [2:0]  e_epoch;
    logic        e_err;
    logic [31:0] e_err_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [31:0] ra,
                     input logic tt, input logic [31:0] ta,
                     input logic bt, input logic [31:0] ba,
                     input logic ft, input logic [31:0] fa,
                     input logic h, input logic rdy,
                     input logic ev, input logic [31:0] ea, input logic [2:0] ee,
                     input logic er, input logic [31:0] eea);
    vec_t v;
    v = '{r, ra, tt, ta, bt, ba, ft, fa, h, rdy, ev, ea, ee, er, eea};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    //   rst  rst_addr      trap             branch           refill           halt  rdy
    //   -> valid addr          epoch err  err_addr
    // Reset with misaligned boot address: aligned load, no error.
    add(1'b1, 32'h8000_0003, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b0, 32'h8000_0000, 3'd0, 1'b0, 32'h0);
    // Reset overrides a misaligned trap.
    add(1'b1, 32'h8000_0000, 1'b1, 32'h11,  1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b0, 32'h8000_0000, 3'd0, 1'b0, 32'h0);
    // First valid fetch one cycle after release, then sequential advance.
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h8000_0000, 3'd0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h8000_0004, 3'd0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h8000_0008, 3'd0, 1'b0, 32'h0);
    // Target without take bit is ignored; stall holds.
    add(1'b0, 32'h0, 1'b0, 32'h999, 1'b0, 32'h777,  1'b0, 32'h555,  1'b0, 1'b0,
        1'b1, 32'h8000_0008, 3'd0, 1'b0, 32'h0);
    // Branch to 0x100 while stalled.
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h100,  1'b0, 32'h0,    1'b0, 1'b0,
        1'b1, 32'h100, 3'd1, 1'b0, 32'h0);
    // Three stall cycles at 0x100, then acceptance.
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0,
        1'b1, 32'h100, 3'd1, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0,
        1'b1, 32'h100, 3'd1, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0,
        1'b1, 32'h100, 3'd1, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h104, 3'd1, 1'b0, 32'h0);
    // All three redirects: trap wins, epoch +1 once, misaligned loser ignored.
    add(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h301,  1'b1, 32'h400,  1'b0, 1'b1,
        1'b1, 32'h200, 3'd2, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0,
        1'b1, 32'h200, 3'd2, 1'b0, 32'h0);
    // Misaligned branch: aligned load, one-cycle pulse, raw target retained.
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h1002, 1'b0, 32'h0,    1'b0, 1'b0,
        1'b1, 32'h1000, 3'd3, 1'b1, 32'h1002);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0,
        1'b1, 32'h1000, 3'd3, 1'b0, 32'h1002);
    // Address wrap.
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0,
        1'b1, 32'hFFFF_FFFC, 3'd4, 1'b0, 32'h1002);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h0, 3'd4, 1'b0, 32'h1002);
    // Epoch wrap 7 -> 0 on refill.
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h10,   1'b0, 1'b1,
        1'b1, 32'h10, 3'd5, 1'b0, 32'h1002);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h20,   1'b0, 1'b1,
        1'b1, 32'h20, 3'd6, 1'b0, 32'h1002);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h30,   1'b0, 1'b1,
        1'b1, 32'h30, 3'd7, 1'b0, 32'h1002);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h40,   1'b0, 1'b1,
        1'b1, 32'h40, 3'd0, 1'b0, 32'h1002);
    // Halt suppresses fetch but not redirects.
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1,
        1'b0, 32'h40, 3'd0, 1'b0, 32'h1002);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h500,  1'b0, 32'h0,    1'b1, 1'b1,
        1'b0, 32'h500, 3'd1, 1'b0, 32'h1002);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1,
        1'b0, 32'h500, 3'd1, 1'b0, 32'h1002);
    // Reset during a pending refill: everything back to reset values.
    add(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h603,  1'b1, 1'b1,
        1'b0, 32'h8000_0000, 3'd0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h8000_0000, 3'd0, 1'b0, 32'h0);
    // Misaligned trap, then halt one cycle, then resume with advance.
    add(1'b0, 32'h0, 1'b1, 32'h7,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h4, 3'd1, 1'b1, 32'h7);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1,
        1'b0, 32'h4, 3'd1, 1'b0, 32'h7);
    add(1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 1'b1,
        1'b1, 32'h8, 3'd1, 1'b0, 32'h7);

    rst = 1'b1; rst_addr = '0; halt = 1'b0; fetch_ready = 1'b0;
    trap_take = 1'b0; branch_take = 1'b0; refill_take = 1'b0;
    trap_addr = '0; branch_addr = '0; refill_addr = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].r;
      rst_addr    = vecs[i].ra;
      trap_take   = vecs[i].tt;
      trap_addr   = vecs[i].ta;
      branch_take = vecs[i].bt;
      branch_addr = vecs[i].ba;
      refill_take = vecs[i].ft;
      refill_addr = vecs[i].fa;
      halt        = vecs[i].h;
      fetch_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d fetch_valid", i), {31'b0, fetch_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d addr", i), addr, vecs[i].e_addr);
      check($sformatf("v%0d epoch", i), {29'b0, epoch}, {29'b0, vecs[i].e_epoch});
      check($sformatf("v%0d misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].e_err});
      check($sformatf("v%0d err_addr", i), err_addr, vecs[i].e_err_addr);
    end

    // fetch_valid follows halt combinationally between edges.
    trap_take = 1'b0; branch_take = 1'b0; refill_take = 1'b0; fetch_ready = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    #1;
    check("comb halt high", {31'b0, fetch_valid}, 32'h0);
    halt = 1'b0;
    #1;
    check("comb halt low", {31'b0, fetch_valid}, 32'h1);
    // Long stall: address holds across several edges.
    repeat (4) @(posedge clk);
    #1;
    check("long stall addr", addr, 32'h8);
    fetch_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall release addr", addr, 32'hC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
